// File: rtl/fare_meter.sv
// Taxi fare meter: synchronizes wheel and button inputs, runs an IDLE/RUN/HOLD
// trip FSM, and accumulates distance, distance fare and waiting-time fare.
module fare_meter #(
  parameter int CLK_PER_SEC = 20000000,
  parameter int BASE_FARE   = 1000,
  parameter int BASE_DIST   = 300,
  parameter int UNIT_FARE   = 2,
  parameter int WAIT_SEC    = 60,
  parameter int WAIT_FARE   = 50
) (
  input  logic        clk20mhz,
  input  logic        rst_n,
  input  logic        wheel_pulse,
  input  logic        start_btn,
  input  logic        stop_btn,
  input  logic        clear_btn,
  output logic [12:0] money_out,
  output logic [12:0] distance_out,
  output logic        running,
  output logic        hold
);

  localparam int TW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int WW = (WAIT_SEC > 1) ? $clog2(WAIT_SEC + 1) : 1;
  localparam logic [12:0] SAT = 13'h1fff;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t state_q, state_d;

  // Bit order: {clear, stop, start, wheel}
  logic [3:0] sync1_q, sync2_q, prev_q, ev;
  logic       wheel_ev, start_ev, stop_ev, clear_ev;

  logic [12:0]   money_q, money_d, dist_q, dist_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          seen_q, seen_d;
  logic          sec_tick, motion, wheel_chg, wait_chg;
  int            money_sum;

  always_ff @(posedge clk20mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {clear_btn, stop_btn, start_btn, wheel_pulse};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign ev       = sync2_q & ~prev_q;
  assign wheel_ev = ev[0];
  assign start_ev = ev[1];
  assign stop_ev  = ev[2];
  assign clear_ev = ev[3];

  assign sec_tick = (timer_q == TW'(CLK_PER_SEC - 1));
  // A wheel event landing on the second boundary still counts as motion.
  assign motion   = seen_q | wheel_ev;

  always_comb begin
    state_d   = state_q;
    money_d   = money_q;
    dist_d    = dist_q;
    timer_d   = timer_q;
    seen_d    = seen_q;
    wait_d    = wait_q;
    wheel_chg = 1'b0;
    wait_chg  = 1'b0;
    money_sum = 0;
    case (state_q)
      IDLE: begin
        if (start_ev) begin
          state_d = RUN;
          money_d = 13'(BASE_FARE);
          dist_d  = '0;
          timer_d = '0;
          seen_d  = 1'b0;
          wait_d  = '0;
        end
      end
      RUN: begin
        if (stop_ev) state_d = HOLD;
        if (wheel_ev && dist_q != SAT) begin
          dist_d    = dist_q + 13'd1;
          wheel_chg = (int'(dist_q) + 1 > BASE_DIST);
        end
        if (sec_tick) begin
          timer_d = '0;
          seen_d  = 1'b0;
          if (!motion) begin
            if (wait_q == WW'(WAIT_SEC - 1)) begin
              wait_d   = '0;
              wait_chg = 1'b1;
            end else begin
              wait_d = wait_q + WW'(1);
            end
          end
        end else begin
          timer_d = timer_q + TW'(1);
          seen_d  = motion;
        end
        money_sum = int'(money_q) + (wheel_chg ? UNIT_FARE : 0) + (wait_chg ? WAIT_FARE : 0);
        money_d   = (money_sum > 8191) ? SAT : money_sum[12:0];
      end
      HOLD: begin
        if (clear_ev) begin
          state_d = IDLE;
          money_d = '0;
          dist_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk20mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      money_q <= '0;
      dist_q  <= '0;
      timer_q <= '0;
      seen_q  <= 1'b0;
      wait_q  <= '0;
      running <= 1'b0;
      hold    <= 1'b0;
    end else begin
      state_q <= state_d;
      money_q <= money_d;
      dist_q  <= dist_d;
      timer_q <= timer_d;
      seen_q  <= seen_d;
      wait_q  <= wait_d;
      running <= (state_d == RUN);
      hold    <= (state_d == HOLD);
    end
  end

  assign money_out    = money_q;
  assign distance_out = dist_q;

endmodule
